// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin sharing of one iterative MulDiv unit between the
// integer pipeline (port 0) and the coprocessor path (port 1).
module muldiv_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rq0_req_valid,
  output logic        rq0_req_ready,
  input  logic [3:0]  rq0_req_bits_fn,
  input  logic        rq0_req_bits_dw,
  input  logic [31:0] rq0_req_bits_in1,
  input  logic [31:0] rq0_req_bits_in2,
  input  logic [4:0]  rq0_req_bits_tag,
  input  logic        rq0_kill,
  input  logic        rq0_resp_ready,
  output logic        rq0_resp_valid,
  output logic [31:0] rq0_resp_bits_data,
  output logic [4:0]  rq0_resp_bits_tag,
  input  logic        rq1_req_valid,
  output logic        rq1_req_ready,
  input  logic [3:0]  rq1_req_bits_fn,
  input  logic        rq1_req_bits_dw,
  input  logic [31:0] rq1_req_bits_in1,
  input  logic [31:0] rq1_req_bits_in2,
  input  logic [4:0]  rq1_req_bits_tag,
  input  logic        rq1_kill,
  input  logic        rq1_resp_ready,
  output logic        rq1_resp_valid,
  output logic [31:0] rq1_resp_bits_data,
  output logic [4:0]  rq1_resp_bits_tag,
  output logic        md_req_valid,
  input  logic        md_req_ready,
  output logic [3:0]  md_req_bits_fn,
  output logic        md_req_bits_dw,
  output logic [31:0] md_req_bits_in1,
  output logic [31:0] md_req_bits_in2,
  output logic [4:0]  md_req_bits_tag,
  output logic        md_kill,
  input  logic        md_resp_valid,
  output logic        md_resp_ready,
  input  logic [31:0] md_resp_bits_data,
  input  logic [4:0]  md_resp_bits_tag,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  logic elig0, elig1, any_elig, grant;
  logic owner_kill, owner_resp_ready, req_fire, resp_fire;

  // A killed port is never eligible; ties go to the port favoured by prio.
  assign elig0            = rq0_req_valid & ~rq0_kill;
  assign elig1            = rq1_req_valid & ~rq1_kill;
  assign any_elig         = elig0 | elig1;
  assign grant            = (elig0 & elig1) ? prio_q : elig1;
  assign owner_kill       = owner_q ? rq1_kill : rq0_kill;
  assign owner_resp_ready = owner_q ? rq1_resp_ready : rq0_resp_ready;
  assign req_fire         = (state_q == IDLE) & any_elig & md_req_ready;
  assign resp_fire        = (state_q == BUSY) & md_resp_valid & owner_resp_ready;

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt0_q  <= 16'h0000;
      cnt1_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = BUSY;
          owner_d = grant;
          prio_d  = ~grant;
        end
      end
      BUSY: begin
        if (resp_fire || owner_kill) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A response delivered in the same cycle as an owner kill still counts.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (resp_fire && !owner_q && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (resp_fire && owner_q && cnt1_q != 16'hFFFF)  cnt1_d = cnt1_q + 16'd1;
  end

  always_comb begin
    md_req_valid       = 1'b0;
    md_req_bits_fn     = 4'd0;
    md_req_bits_dw     = 1'b0;
    md_req_bits_in1    = 32'd0;
    md_req_bits_in2    = 32'd0;
    md_req_bits_tag    = 5'd0;
    md_kill            = 1'b0;
    md_resp_ready      = 1'b0;
    rq0_req_ready      = 1'b0;
    rq1_req_ready      = 1'b0;
    rq0_resp_valid     = 1'b0;
    rq0_resp_bits_data = 32'd0;
    rq0_resp_bits_tag  = 5'd0;
    rq1_resp_valid     = 1'b0;
    rq1_resp_bits_data = 32'd0;
    rq1_resp_bits_tag  = 5'd0;
    // Outputs are forced quiet while reset is held, independent of the clock.
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            md_req_valid = 1'b1;
            if (grant) begin
              md_req_bits_fn  = rq1_req_bits_fn;
              md_req_bits_dw  = rq1_req_bits_dw;
              md_req_bits_in1 = rq1_req_bits_in1;
              md_req_bits_in2 = rq1_req_bits_in2;
              md_req_bits_tag = rq1_req_bits_tag;
              rq1_req_ready   = md_req_ready;
            end else begin
              md_req_bits_fn  = rq0_req_bits_fn;
              md_req_bits_dw  = rq0_req_bits_dw;
              md_req_bits_in1 = rq0_req_bits_in1;
              md_req_bits_in2 = rq0_req_bits_in2;
              md_req_bits_tag = rq0_req_bits_tag;
              rq0_req_ready   = md_req_ready;
            end
          end
        end
        BUSY: begin
          md_kill       = owner_kill;
          md_resp_ready = owner_resp_ready;
          if (owner_q) begin
            rq1_resp_valid     = md_resp_valid;
            rq1_resp_bits_data = md_resp_bits_data;
            rq1_resp_bits_tag  = md_resp_bits_tag;
          end else begin
            rq0_resp_valid     = md_resp_valid;
            rq0_resp_bits_data = md_resp_bits_data;
            rq0_resp_bits_tag  = md_resp_bits_tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: a small MulDiv stand-in, a transaction-level model
// of the arbiter's rules, table-driven grant vectors and directed sequences.
module tb_muldiv_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rq0_req_valid, rq0_req_ready, rq0_req_bits_dw, rq0_kill, rq0_resp_ready, rq0_resp_valid;
  logic [3:0]  rq0_req_bits_fn;
  logic [31:0] rq0_req_bits_in1, rq0_req_bits_in2, rq0_resp_bits_data;
  logic [4:0]  rq0_req_bits_tag, rq0_resp_bits_tag;
  logic        rq1_req_valid, rq1_req_ready, rq1_req_bits_dw, rq1_kill, rq1_resp_ready, rq1_resp_valid;
  logic [3:0]  rq1_req_bits_fn;
  logic [31:0] rq1_req_bits_in1, rq1_req_bits_in2, rq1_resp_bits_data;
  logic [4:0]  rq1_req_bits_tag, rq1_resp_bits_tag;
  logic        md_req_valid, md_req_ready, md_req_bits_dw, md_kill, md_resp_valid, md_resp_ready;
  logic [3:0]  md_req_bits_fn;
  logic [31:0] md_req_bits_in1, md_req_bits_in2, md_resp_bits_data;
  logic [4:0]  md_req_bits_tag, md_resp_bits_tag;
  logic [15:0] cnt0, cnt1;

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clock = ~clock;

  muldiv_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .rq0_req_valid(rq0_req_valid), .rq0_req_ready(rq0_req_ready),
    .rq0_req_bits_fn(rq0_req_bits_fn), .rq0_req_bits_dw(rq0_req_bits_dw),
    .rq0_req_bits_in1(rq0_req_bits_in1), .rq0_req_bits_in2(rq0_req_bits_in2),
    .rq0_req_bits_tag(rq0_req_bits_tag), .rq0_kill(rq0_kill),
    .rq0_resp_ready(rq0_resp_ready), .rq0_resp_valid(rq0_resp_valid),
    .rq0_resp_bits_data(rq0_resp_bits_data), .rq0_resp_bits_tag(rq0_resp_bits_tag),
    .rq1_req_valid(rq1_req_valid), .rq1_req_ready(rq1_req_ready),
    .rq1_req_bits_fn(rq1_req_bits_fn), .rq1_req_bits_dw(rq1_req_bits_dw),
    .rq1_req_bits_in1(rq1_req_bits_in1), .rq1_req_bits_in2(rq1_req_bits_in2),
    .rq1_req_bits_tag(rq1_req_bits_tag), .rq1_kill(rq1_kill),
    .rq1_resp_ready(rq1_resp_ready), .rq1_resp_valid(rq1_resp_valid),
    .rq1_resp_bits_data(rq1_resp_bits_data), .rq1_resp_bits_tag(rq1_resp_bits_tag),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_bits_fn(md_req_bits_fn), .md_req_bits_dw(md_req_bits_dw),
    .md_req_bits_in1(md_req_bits_in1), .md_req_bits_in2(md_req_bits_in2),
    .md_req_bits_tag(md_req_bits_tag), .md_kill(md_kill),
    .md_resp_valid(md_resp_valid), .md_resp_ready(md_resp_ready),
    .md_resp_bits_data(md_resp_bits_data), .md_resp_bits_tag(md_resp_bits_tag),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  function automatic logic [31:0] ref_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      4'd4:    return $signed(a) / $signed(b);
      4'd5:    return a / b;
      4'd6:    return $signed(a) % $signed(b);
      4'd7:    return a % b;
      default: return a * b;
    endcase
  endfunction

  // MulDiv stand-in: idle when not busy, answers mock_lat cycles after accept.
  logic        md_busy;
  logic [2:0]  md_wait;
  logic [31:0] md_result;
  logic [4:0]  md_tag;
  logic        md_gate = 1'b1;
  logic [2:0]  mock_lat = 3'd1;

  assign md_req_ready      = ~md_busy & md_gate;
  assign md_resp_valid     = md_busy & (md_wait == 3'd0);
  assign md_resp_bits_data = md_result;
  assign md_resp_bits_tag  = md_tag;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_busy   <= 1'b0;
      md_wait   <= 3'd0;
      md_result <= 32'd0;
      md_tag    <= 5'd0;
    end else if (md_busy) begin
      if (md_kill || (md_resp_valid && md_resp_ready)) md_busy <= 1'b0;
      else if (md_wait != 3'd0) md_wait <= md_wait - 3'd1;
    end else if (md_req_valid && md_req_ready) begin
      md_busy   <= 1'b1;
      md_wait   <= mock_lat;
      md_result <= ref_op(md_req_bits_fn, md_req_bits_in1, md_req_bits_in2);
      md_tag    <= md_req_bits_tag;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one op in flight at a time, owned by one port.
  logic        m_busy, m_owner, m_fav;
  logic [15:0] m_cnt[2];
  logic [3:0]  m_fn;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_tag;
  logic [31:0] last_data[2];
  logic [4:0]  last_tag[2];
  int          grant_log[$];

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        check_output("rst_md_req_valid", {31'd0, md_req_valid}, 32'd0);
        check_output("rst_resp_valid", {30'd0, rq0_resp_valid, rq1_resp_valid}, 32'd0);
        check_output("rst_cnt", {cnt0, cnt1}, 32'd0);
        m_busy = 1'b0; m_owner = 1'b0; m_fav = 1'b0;
        m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
      end else begin
        logic e0, e1, g, mdv, kill_o, rr_o;
        check_output("cnt0", {16'd0, cnt0}, {16'd0, m_cnt[0]});
        check_output("cnt1", {16'd0, cnt1}, {16'd0, m_cnt[1]});
        e0 = rq0_req_valid && !rq0_kill;
        e1 = rq1_req_valid && !rq1_kill;
        if (!m_busy) begin
          g   = (e0 && e1) ? m_fav : e1;
          mdv = e0 || e1;
          check_output("idle_md_req_valid", {31'd0, md_req_valid}, {31'd0, mdv});
          check_output("idle_rq0_ready", {31'd0, rq0_req_ready}, {31'd0, mdv && !g && md_req_ready});
          check_output("idle_rq1_ready", {31'd0, rq1_req_ready}, {31'd0, mdv && g && md_req_ready});
          check_output("idle_md_kill", {31'd0, md_kill}, 32'd0);
          check_output("idle_resp_valid", {30'd0, rq0_resp_valid, rq1_resp_valid}, 32'd0);
          if (mdv) begin
            check_output("idle_md_tag", {27'd0, md_req_bits_tag}, {27'd0, g ? rq1_req_bits_tag : rq0_req_bits_tag});
            check_output("idle_md_in1", md_req_bits_in1, g ? rq1_req_bits_in1 : rq0_req_bits_in1);
          end
          if (mdv && md_req_ready) begin
            m_busy  = 1'b1;
            m_owner = g;
            m_fav   = !g;
            m_fn    = g ? rq1_req_bits_fn : rq0_req_bits_fn;
            m_a     = g ? rq1_req_bits_in1 : rq0_req_bits_in1;
            m_b     = g ? rq1_req_bits_in2 : rq0_req_bits_in2;
            m_tag   = g ? rq1_req_bits_tag : rq0_req_bits_tag;
            grant_log.push_back(int'(g));
          end
        end else begin
          kill_o = m_owner ? rq1_kill : rq0_kill;
          rr_o   = m_owner ? rq1_resp_ready : rq0_resp_ready;
          check_output("busy_req_side", {29'd0, md_req_valid, rq0_req_ready, rq1_req_ready}, 32'd0);
          check_output("busy_md_kill", {31'd0, md_kill}, {31'd0, kill_o});
          check_output("busy_md_resp_ready", {31'd0, md_resp_ready}, {31'd0, rr_o});
          check_output("busy_owner_valid", {31'd0, m_owner ? rq1_resp_valid : rq0_resp_valid}, {31'd0, md_resp_valid});
          check_output("busy_other_valid", {31'd0, m_owner ? rq0_resp_valid : rq1_resp_valid}, 32'd0);
          check_output("busy_other_data", m_owner ? rq0_resp_bits_data : rq1_resp_bits_data, 32'd0);
          if (md_resp_valid) begin
            check_output("resp_data", m_owner ? rq1_resp_bits_data : rq0_resp_bits_data, ref_op(m_fn, m_a, m_b));
            check_output("resp_tag", {27'd0, m_owner ? rq1_resp_bits_tag : rq0_resp_bits_tag}, {27'd0, m_tag});
          end
          if (md_resp_valid && rr_o) begin
            if (m_cnt[m_owner] != 16'hFFFF) m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
            last_data[m_owner] = ref_op(m_fn, m_a, m_b);
            last_tag[m_owner]  = m_tag;
          end
          if ((md_resp_valid && rr_o) || kill_o) m_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic       v0, k0, v1, k1, mdr;
    logic       r0, r1, mdv, mdk;
    logic [4:0] tag;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rq0_req_valid = 0; rq0_kill = 0; rq0_req_bits_fn = 0; rq0_req_bits_dw = 0;
    rq0_req_bits_in1 = 0; rq0_req_bits_in2 = 0; rq0_req_bits_tag = 0;
    rq1_req_valid = 0; rq1_kill = 0; rq1_req_bits_fn = 0; rq1_req_bits_dw = 0;
    rq1_req_bits_in1 = 0; rq1_req_bits_in2 = 0; rq1_req_bits_tag = 0;
    rq0_resp_ready = 1; rq1_resp_ready = 1; md_gate = 1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
  endtask

  task automatic apply_stimulus(input int port, input logic [3:0] fn, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] tag);
    if (port == 0) begin
      rq0_req_bits_fn = fn; rq0_req_bits_in1 = a; rq0_req_bits_in2 = b; rq0_req_bits_tag = tag;
      rq0_req_bits_dw = 1; rq0_req_valid = 1;
    end else begin
      rq1_req_bits_fn = fn; rq1_req_bits_in1 = a; rq1_req_bits_in2 = b; rq1_req_bits_tag = tag;
      rq1_req_bits_dw = 1; rq1_req_valid = 1;
    end
  endtask

  task automatic issue(input int port, input logic [3:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    apply_stimulus(port, fn, a, b, tag);
    #1;
    while (!(port == 0 ? rq0_req_ready : rq1_req_ready) && n < 50) begin
      tick();
      n++;
    end
    check_output("issue_grant", {31'd0, port == 0 ? rq0_req_ready : rq1_req_ready}, 32'd1);
    tick();
    if (port == 0) rq0_req_valid = 0; else rq1_req_valid = 0;
  endtask

  task automatic await_resp(input int port, input logic [31:0] exp_data, input logic [4:0] exp_tag);
    int n = 0;
    while (!(port == 0 ? rq0_resp_valid : rq1_resp_valid) && n < 50) begin
      tick();
      n++;
    end
    check_output("resp_seen", {31'd0, port == 0 ? rq0_resp_valid : rq1_resp_valid}, 32'd1);
    check_output("resp_value", port == 0 ? rq0_resp_bits_data : rq1_resp_bits_data, exp_data);
    check_output("resp_tag_value", {27'd0, port == 0 ? rq0_resp_bits_tag : rq1_resp_bits_tag}, {27'd0, exp_tag});
    tick();
  endtask

  initial begin
    int g0, g1, n;
    logic [15:0] c1_before;

    vecs[0] = '{0,0,0,0,1, 0,0,0,0, 5'd0};
    vecs[1] = '{1,0,0,0,1, 1,0,1,0, 5'd10};
    vecs[2] = '{0,0,1,0,1, 0,1,1,0, 5'd20};
    vecs[3] = '{1,0,1,0,1, 1,0,1,0, 5'd10};
    vecs[4] = '{1,1,1,0,1, 0,1,1,0, 5'd20};
    vecs[5] = '{1,0,1,1,1, 1,0,1,0, 5'd10};
    vecs[6] = '{1,1,1,1,1, 0,0,0,0, 5'd0};
    vecs[7] = '{1,0,1,0,0, 0,0,1,0, 5'd10};
    vecs[8] = '{0,1,0,0,1, 0,0,0,0, 5'd0};

    clear_inputs();
    do_reset();

    // Grant vectors applied and withdrawn within one cycle, so nothing fires.
    foreach (vecs[i]) begin
      tick();
      rq0_req_bits_tag = 5'd10; rq0_req_bits_in1 = 32'h111;
      rq1_req_bits_tag = 5'd20; rq1_req_bits_in1 = 32'h222;
      rq0_req_valid = vecs[i].v0; rq0_kill = vecs[i].k0;
      rq1_req_valid = vecs[i].v1; rq1_kill = vecs[i].k1;
      md_gate = vecs[i].mdr;
      #1;
      check_output("vec_rq0_ready", {31'd0, rq0_req_ready}, {31'd0, vecs[i].r0});
      check_output("vec_rq1_ready", {31'd0, rq1_req_ready}, {31'd0, vecs[i].r1});
      check_output("vec_md_valid", {31'd0, md_req_valid}, {31'd0, vecs[i].mdv});
      check_output("vec_md_kill", {31'd0, md_kill}, {31'd0, vecs[i].mdk});
      check_output("vec_md_tag", {27'd0, md_req_bits_tag}, {27'd0, vecs[i].tag});
      #1 clear_inputs();
    end

    // Single port-0 multiply.
    tick();
    mock_lat = 3'd2;
    apply_stimulus(0, 4'd0, 32'd7, 32'd6, 5'd3);
    #1 check_output("a_grant_cycle0", {31'd0, rq0_req_ready}, 32'd1);
    tick();
    rq0_req_valid = 0;
    await_resp(0, 32'd42, 5'd3);
    check_output("a_cnt0", {16'd0, cnt0}, 32'd1);
    check_output("a_cnt1", {16'd0, cnt1}, 32'd0);

    // Both ports saturating the unit: grants must alternate.
    do_reset();
    grant_log.delete();
    mock_lat = 3'd1;
    apply_stimulus(0, 4'd4, 32'd100, 32'd7, 5'd1);
    apply_stimulus(1, 4'd6, 32'd100, 32'd7, 5'd2);
    g0 = 0; g1 = 0; n = 0;
    while ((g0 < 4 || g1 < 4) && n < 200) begin
      #1;
      if (rq0_req_valid && rq0_req_ready) g0++;
      if (rq1_req_valid && rq1_req_ready) g1++;
      tick();
      if (g0 >= 4) rq0_req_valid = 0;
      if (g1 >= 4) rq1_req_valid = 0;
      n++;
    end
    repeat (6) tick();
    check_output("b_grant_count", grant_log.size(), 32'd8);
    foreach (grant_log[i]) check_output("b_alternate", grant_log[i], i % 2);
    check_output("b_port0_data", last_data[0], 32'd14);
    check_output("b_port0_tag", {27'd0, last_tag[0]}, 32'd1);
    check_output("b_port1_data", last_data[1], 32'd2);
    check_output("b_port1_tag", {27'd0, last_tag[1]}, 32'd2);
    check_output("b_cnt", {cnt0, cnt1}, {16'd4, 16'd4});

    // Owner kill on port 1 with port 0 waiting.
    mock_lat = 3'd4;
    c1_before = cnt1;
    issue(1, 4'd4, 32'd100, 32'd7, 5'd9);
    tick();
    apply_stimulus(0, 4'd0, 32'd3, 32'd5, 5'd4);
    rq1_kill = 1;
    #1;
    check_output("c_md_kill", {31'd0, md_kill}, 32'd1);
    check_output("c_no_grant_kill_cycle", {31'd0, rq0_req_ready}, 32'd0);
    tick();
    rq1_kill = 0;
    #1;
    check_output("c_grant_after_kill", {31'd0, rq0_req_ready}, 32'd1);
    check_output("c_cnt1_unchanged", {16'd0, cnt1}, {16'd0, c1_before});
    tick();
    rq0_req_valid = 0;
    await_resp(0, 32'd15, 5'd4);

    // Non-owner kill is ignored.
    mock_lat = 3'd3;
    issue(0, 4'd0, 32'd9, 32'd9, 5'd6);
    tick();
    rq1_kill = 1;
    #1 check_output("d_md_kill_low", {31'd0, md_kill}, 32'd0);
    tick();
    rq1_kill = 0;
    await_resp(0, 32'd81, 5'd6);

    // Response backpressure on port 0 while port 1 waits.
    mock_lat = 3'd0;
    rq0_resp_ready = 0;
    issue(0, 4'd0, 32'd11, 32'd3, 5'd7);
    apply_stimulus(1, 4'd5, 32'd50, 32'd5, 5'd8);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("e_md_resp_ready", {31'd0, md_resp_ready}, 32'd0);
      check_output("e_resp_held", {31'd0, rq0_resp_valid}, 32'd1);
      check_output("e_data_stable", rq0_resp_bits_data, 32'd33);
      check_output("e_rq1_waits", {31'd0, rq1_req_ready}, 32'd0);
      tick();
    end
    rq0_resp_ready = 1;
    #1 check_output("e_md_resp_ready_on", {31'd0, md_resp_ready}, 32'd1);
    tick();
    #1 check_output("e_rq1_granted", {31'd0, rq1_req_ready}, 32'd1);
    tick();
    rq1_req_valid = 0;
    await_resp(1, 32'd10, 5'd8);

    // Counter saturation from a preloaded value near the top.
    force dut.cnt0_q = 16'hFFFE;
    m_cnt[0] = 16'hFFFE;
    tick();
    tick();
    release dut.cnt0_q;
    check_output("f_preload", {16'd0, cnt0}, 32'h0000FFFE);
    mock_lat = 3'd1;
    issue(0, 4'd0, 32'd2, 32'd2, 5'd1);
    await_resp(0, 32'd4, 5'd1);
    check_output("f_cnt0_top", {16'd0, cnt0}, 32'h0000FFFF);
    issue(0, 4'd0, 32'd2, 32'd3, 5'd1);
    await_resp(0, 32'd6, 5'd1);
    check_output("f_cnt0_saturated", {16'd0, cnt0}, 32'h0000FFFF);

    // Reset asserted mid-op, between clock edges.
    mock_lat = 3'd7;
    issue(0, 4'd0, 32'd5, 32'd5, 5'd2);
    apply_stimulus(1, 4'd0, 32'hABCD, 32'd1, 5'd17);
    #2 reset_n = 0;
    #1;
    check_output("g_md_req_valid", {31'd0, md_req_valid}, 32'd0);
    check_output("g_rq1_ready", {31'd0, rq1_req_ready}, 32'd0);
    check_output("g_md_fields", md_req_bits_in1, 32'd0);
    check_output("g_md_tag", {27'd0, md_req_bits_tag}, 32'd0);
    check_output("g_md_resp_ready", {31'd0, md_resp_ready}, 32'd0);
    check_output("g_md_kill", {31'd0, md_kill}, 32'd0);
    check_output("g_cnt0", {16'd0, cnt0}, 32'd0);
    do_reset();

    // Randomized traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] fns[3];
      fns[0] = 4'd0; fns[1] = 4'd5; fns[2] = 4'd7;
      tick();
      rq0_req_valid = ($urandom_range(0, 9) < 6);
      rq1_req_valid = ($urandom_range(0, 9) < 6);
      rq0_kill = ($urandom_range(0, 19) == 0);
      rq1_kill = ($urandom_range(0, 19) == 0);
      rq0_resp_ready = ($urandom_range(0, 3) != 0);
      rq1_resp_ready = ($urandom_range(0, 3) != 0);
      rq0_req_bits_fn = fns[$urandom_range(0, 2)];
      rq1_req_bits_fn = fns[$urandom_range(0, 2)];
      rq0_req_bits_in1 = $urandom; rq0_req_bits_in2 = $urandom_range(1, 1000);
      rq1_req_bits_in1 = $urandom; rq1_req_bits_in2 = $urandom_range(1, 1000);
      rq0_req_bits_tag = 5'($urandom_range(0, 31));
      rq1_req_bits_tag = 5'($urandom_range(0, 31));
      mock_lat = 3'($urandom_range(0, 3));
    end
    clear_inputs();
    repeat (10) tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
